// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that time-shares one external adder between requesters.
// Operands and result are registered; one op in flight at a time.
module add_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int IDW     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       gnt;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 found;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;
  logic [NUM_REQ-1:0]   rsp_oh;
  logic                 accept;
  logic [IDW-1:0]       ptr_nxt;

  // two passes: indices at/above rr_ptr first, then the wrapped ones
  always_comb begin
    found  = 1'b0;
    gnt    = '0;
    gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && IDW'(i) >= rr_ptr) begin
        found     = 1'b1;
        gnt       = IDW'(i);
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && IDW'(i) < rr_ptr) begin
        found     = 1'b1;
        gnt       = IDW'(i);
        gnt_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    rsp_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
      if (rsp_id == IDW'(i)) begin
        rsp_oh[i] = 1'b1;
      end
    end
  end

  // rsp_valid is one-hot on the owner, so this ignores other ready bits
  assign accept  = (state_q == RESP) && |(rsp_ready & rsp_valid);
  assign ptr_nxt = (rsp_id == IDW'(NUM_REQ-1)) ? '0 : rsp_id + IDW'(1);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst_n ? gnt_oh : '0;
        if (found) state_d = CALC;
      end
      CALC: state_d = RESP;
      RESP: if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_valid <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            rsp_id <= gnt;
          end
        end
        CALC: begin
          rsp_sum   <= add_sum;
          rsp_valid <= rsp_oh;
        end
        RESP: begin
          if (accept) begin
            rsp_valid <= '0;
            rr_ptr    <= ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: directed cases plus random traffic
// against a round-robin / modular-sum reference model.
module tb_add_share_arbiter;

  localparam int N   = 3;
  localparam int W   = 32;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_sum;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic [IDW-1:0] rsp_id;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;
  int cnt [N];

  always #5 clk = ~clk;

  // the external adder
  assign add_sum = add_a + add_b;

  add_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] vm);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (vm[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_op(input logic [N-1:0] vm, input int hold,
                        input logic [W-1:0] fa, input logic [W-1:0] fb,
                        input bit force_ab);
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic [W:0]   full;
    logic [W-1:0] es;
    int g;
    for (int i = 0; i < N; i++) begin
      a[i] = force_ab ? fa : W'($urandom);
      b[i] = force_ab ? fb : W'($urandom);
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
    end
    req_valid = vm;
    rsp_ready = '0;
    #1;
    g = exp_grant(vm);
    chk("req_ready_idle", req_ready, oh(g));
    chk("busy_idle", busy, 1'b0);
    if (g < 0) begin
      req_valid = '0;
      step();
      return;
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
    full = {1'b0, a[g]} + {1'b0, b[g]};
    es = full[W-1:0];
    step();
    #1;
    chk("add_a", add_a, a[g]);
    chk("add_b", add_b, b[g]);
    chk("rsp_id_calc", rsp_id, g);
    chk("busy_calc", busy, 1'b1);
    chk("rsp_valid_calc", rsp_valid, '0);
    chk("req_ready_calc", req_ready, '0);
    step();
    chk("rsp_valid", rsp_valid, oh(g));
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_id", rsp_id, g);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh(g) & N'($urandom);
      #1;
      chk("req_ready_resp", req_ready, '0);
      step();
      chk("hold_rsp_valid", rsp_valid, oh(g));
      chk("hold_rsp_sum", rsp_sum, es);
      chk("hold_busy", busy, 1'b1);
    end
    rsp_ready = oh(g) | (~oh(g) & N'($urandom));
    step();
    rsp_ready = '0;
    req_valid = '0;
    #1;
    chk("rsp_valid_done", rsp_valid, '0);
    chk("busy_done", busy, 1'b0);
    model_ptr = (g + 1) % N;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    step();
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, '0);
    step();
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_sum", rsp_sum, '0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_add_a", add_a, '0);
    chk("rst_busy", busy, 1'b0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    run_op('0, 0, '0, '0, 1'b0);
    run_op(3'b001, 0, 32'h0000_0005, 32'h0000_0007, 1'b1);
    chk("single_sum_const", rsp_sum, 32'h0000_000C);
    run_op(3'b001, 0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    chk("wrap_sum_const", rsp_sum, 32'h0000_0001);
    run_op(3'b001, 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    chk("ovf_sum_const", rsp_sum, 32'h0000_0000);

    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) run_op(3'b011, 0, '0, '0, 1'b0);
    chk("rr_cnt0", cnt[0], 4);
    chk("rr_cnt1", cnt[1], 4);

    run_op(3'b001, 5, '0, '0, 1'b0);

    for (int k = 0; k < 30; k++)
      run_op(N'($urandom_range(0, 7)), $urandom_range(0, 3), '0, '0, 1'b0);

    // reset while in CALC drops the op and restarts arbitration at 0
    run_op(3'b001, 0, '0, '0, 1'b0);
    req_a[0 +: W] = 32'h1234_5678;
    req_b[0 +: W] = 32'h1111_1111;
    req_valid = 3'b001;
    step();
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_calc_ready", req_ready, '0);
    step();
    chk("rst_calc_busy", busy, 1'b0);
    chk("rst_calc_valid", rsp_valid, '0);
    chk("rst_calc_sum", rsp_sum, '0);
    chk("rst_calc_id", rsp_id, '0);
    chk("rst_calc_add_b", add_b, '0);
    rst_n = 1'b1;
    req_valid = '0;
    model_ptr = 0;
    step();
    step();
    chk("post_rst_valid", rsp_valid, '0);
    run_op(3'b111, 1, '0, '0, 1'b0);
    chk("post_rst_id", rsp_id, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
